// File: rtl/instr_fetch.sv
// instr_fetch: PC register plus small fetch queue feeding decode; optional
// accepted-instruction counter on fetch_count when IFETCH_PERF_CNT_EN is defined.
module instr_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] Rom_addr,
  input  logic [31:0] Rom_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count
`endif
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam logic [PW:0] DEPTH = (PW+1)'(QUEUE_DEPTH);
  logic [31:0] pc_q, pc_d;
  logic [PW:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [31:0] mem_pc_q [QUEUE_DEPTH];
  logic [31:0] mem_pc_d [QUEUE_DEPTH];
  logic [31:0] mem_instr_q [QUEUE_DEPTH];
  logic [31:0] mem_instr_d [QUEUE_DEPTH];
  logic pop, push;
  assign Rom_addr = pc_q;
  assign if_valid = count_q != '0;
  assign if_instr = mem_instr_q[rd_ptr_q];
  assign if_pc    = mem_pc_q[rd_ptr_q];
  // Next-state: redirect flushes and retargets; otherwise push at tail and pop at head.
  always_comb begin
    pop         = if_valid && if_ready;
    push        = fetch_en && !redirect_valid && (count_q < DEPTH || pop);
    pc_d        = pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_pc_d    = mem_pc_q;
    mem_instr_d = mem_instr_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        mem_pc_d[wr_ptr_q]    = pc_q;
        mem_instr_d[wr_ptr_q] = Rom_data;
        wr_ptr_d              = wr_ptr_q + PW'(1);
        pc_d                  = pc_q + 32'd4;
      end
      rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // State registers; reset empties the queue immediately and parks the head on a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_pc_q[i]    <= '0;
        mem_instr_q[i] <= 32'h0000_0013;
      end
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      mem_pc_q    <= mem_pc_d;
      mem_instr_q <= mem_instr_d;
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  assign fetch_count = fetch_count_q;
  // Count only pops that take effect; a pop squashed by redirect is not counted.
  always_comb fetch_count_d = fetch_count_q + 32'(pop && !redirect_valid);
  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_count_q <= '0;
    else fetch_count_q <= fetch_count_d;
  end
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus random traffic against a queue-based reference model.
module tb_instr_fetch;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic        if_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] Rom_addr, Rom_data, if_instr, if_pc;
  logic        if_valid;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] mq [$];
  logic [31:0] mpc, mfc;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .Rom_addr(Rom_addr),
    .Rom_data(Rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .if_valid(if_valid),
    .if_ready(if_ready),
    .if_instr(if_instr),
    .if_pc(if_pc)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  function automatic logic [31:0] rom_rd(input logic [31:0] a);
    if (a == 32'h0) return 32'hFE01_0113;
    if (a == 32'h4) return 32'h0011_2E23;
    if (a == 32'h1C) return 32'h000F_8713;
    if (a < 32'h100) return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
    return 32'h0000_0013;
  endfunction

  assign Rom_data = rom_rd(Rom_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset;
    mq.delete();
    mpc = 32'h0;
    mfc = 32'h0;
  endtask

  task automatic compare_all;
    check("valid", {31'b0, if_valid}, {31'b0, mq.size() != 0});
    check("rom_addr", Rom_addr, mpc);
    if (mq.size() != 0) begin
      check("head_pc", if_pc, mq[0][63:32]);
      check("head_instr", if_instr, mq[0][31:0]);
    end
`ifdef IFETCH_PERF_CNT_EN
    check("fetch_count", fetch_count, mfc);
`endif
  endtask

  task automatic cycle;
    bit pop, push;
    @(posedge clk);
    pop  = mq.size() != 0 && if_ready;
    push = fetch_en && !redirect_valid && (mq.size() < DEPTH || pop);
    if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        mfc = mfc + 1;
      end
      if (push) begin
        mq.push_back({mpc, rom_rd(mpc)});
        mpc = mpc + 32'd4;
      end
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", {31'b0, if_valid}, 32'h0);
    check("rst_instr", if_instr, 32'h0000_0013);
    check("rst_pc", if_pc, 32'h0);
    check("rst_addr", Rom_addr, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_fetch_count", fetch_count, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1; fetch_en = 1'b1; if_ready = 1'b1;
    cycle();
    check("first_pc", if_pc, 32'h0);
    check("first_instr", if_instr, 32'hFE01_0113);
    cycle();
    check("second_pc", if_pc, 32'h4);
    check("second_instr", if_instr, 32'h0011_2E23);
    if_ready = 1'b0;
    do_reset();
    repeat (5) cycle();
    check("stall_addr", Rom_addr, 32'h8);
    check("stall_valid", {31'b0, if_valid}, 32'h1);
    check("stall_pc", if_pc, 32'h0);
    check("stall_instr", if_instr, 32'hFE01_0113);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_001E;
    cycle();
    check("redir_valid", {31'b0, if_valid}, 32'h0);
    check("redir_addr", Rom_addr, 32'h1C);
    redirect_valid = 1'b0;
    cycle();
    check("redir_pc", if_pc, 32'h1C);
    check("redir_instr", if_instr, 32'h000F_8713);
    if_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
    cycle();
    check("squash_valid", {31'b0, if_valid}, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    check("squash_count", fetch_count, 32'h0);
`endif
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    check("wrap_pre_addr", Rom_addr, 32'hFFFF_FFFC);
    redirect_valid = 1'b0;
    cycle();
    check("wrap_addr", Rom_addr, 32'h0);
    check("wrap_pc", if_pc, 32'hFFFF_FFFC);
    check("wrap_instr", if_instr, 32'h0000_0013);
    if_ready = 1'b0;
    cycle();
    cycle();
    check("pre_pulse_valid", {31'b0, if_valid}, 32'h1);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    check("pulse_valid", {31'b0, if_valid}, 32'h0);
    check("pulse_addr", Rom_addr, 32'h0);
    #2 rst_n = 1'b1;
    cycle();
    check("restart_pc", if_pc, 32'h0);
    check("restart_instr", if_instr, 32'hFE01_0113);
    for (int i = 0; i < 600; i++) begin
      fetch_en       = $urandom_range(0, 3) != 0;
      if_ready       = $urandom_range(0, 4) > 1;
      redirect_valid = $urandom_range(0, 15) == 0;
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : 32'($urandom_range(0, 255));
      cycle();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
